// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 8-digit 7-segment scan scheduler.
package seg_scan_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  localparam int NUM_DIGITS = 8;
  localparam int SEG_W = 7;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;
endpackage

// File: rtl/seg_scan_scheduler_timer.sv
// Down-counting slot timer: load sets the count, tc is high while the count is zero.
// Latency: tc follows a load by one cycle; the count holds at zero rather than wrapping.
module scan_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);
endmodule

// File: rtl/seg_scan_scheduler.sv
// Multiplexed 8-digit display scanner: blank gap then drive window per digit, frame-latched patterns.
// Outputs are registered from the current state (one cycle behind it); there is no backpressure.
module seg_scan_scheduler
  import seg_scan_pkg::*;
#(
  parameter int DRIVE_CYC = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  output logic [SEG_W-1:0]            segment,
  output logic [NUM_DIGITS-1:0]       anode_ctrl,
  output logic                        frame_tick
);
  localparam int MAX_CYC = (DRIVE_CYC > BLANK_CYC) ? DRIVE_CYC : BLANK_CYC;
  localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] DRIVE_LOAD = TW'(DRIVE_CYC - 1);
  localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYC - 1);

  state_t                        state;
  logic [2:0]                    idx;
  logic [NUM_DIGITS*SEG_W-1:0]   shadow;
  logic                          load;
  logic [TW-1:0]                 load_val;
  logic                          tc;
  logic                          lit;

  scan_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  // Timer is reloaded on every slot boundary and forced to zero whenever the scan is off.
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    case (state)
      IDLE: begin
        load     = 1'b1;
        load_val = enable ? BLANK_LOAD : '0;
      end
      BLANK: begin
        if (!enable) begin
          load = 1'b1;
        end else if (tc) begin
          load     = 1'b1;
          load_val = DRIVE_LOAD;
        end
      end
      DRIVE: begin
        if (!enable) begin
          load = 1'b1;
        end else if (tc) begin
          load     = 1'b1;
          load_val = BLANK_LOAD;
        end
      end
      default: load = 1'b1;
    endcase
  end

  assign lit = (state == DRIVE) && digit_en[idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= 3'd0;
      shadow     <= '0;
      segment    <= '0;
      anode_ctrl <= ANODE_OFF;
      frame_tick <= 1'b0;
    end else begin
      segment    <= lit ? shadow[idx*SEG_W +: SEG_W] : '0;
      anode_ctrl <= lit ? ~(NUM_DIGITS'(1) << idx) : ANODE_OFF;
      frame_tick <= enable && (state == DRIVE) && (idx == 3'(NUM_DIGITS - 1)) && tc;
      case (state)
        IDLE: begin
          if (enable) begin
            state  <= BLANK;
            idx    <= 3'd0;
            shadow <= seg_data;
          end
        end
        BLANK: begin
          if (!enable) begin
            state <= IDLE;
          end else if (tc) begin
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (!enable) begin
            state <= IDLE;
          end else if (tc) begin
            state <= BLANK;
            idx   <= idx + 3'd1;
            // New patterns are only latched at the frame boundary so a frame never tears.
            if (idx == 3'(NUM_DIGITS - 1)) begin
              shadow <= seg_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Randomized scoreboard bench for seg_scan_scheduler against a frame-position reference model.
module tb_seg_scan_scheduler;
  localparam int DRV = 4;
  localparam int BLK = 2;
  localparam int SLOT = DRV + BLK;
  localparam int FRAME = 8 * SLOT;

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] an;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [55:0] seg_data = '0;
  logic [7:0]  digit_en = 8'hFF;
  logic [6:0]  segment;
  logic [7:0]  anode_ctrl;
  logic        frame_tick;

  exp_t q[$];
  exp_t exp_last;
  int   pos = -1;
  logic [6:0] m_shadow [8];
  int   total = 0;
  int   passed = 0;

  seg_scan_scheduler #(.DRIVE_CYC(DRV), .BLANK_CYC(BLK)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .seg_data   (seg_data),
    .digit_en   (digit_en),
    .segment    (segment),
    .anode_ctrl (anode_ctrl),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // Reference: scan position within the frame (-1 = off); outputs lag the position by one cycle.
  task automatic model_step();
    exp_t e;
    int   slot;
    int   off;
    e = '{seg: 7'd0, an: 8'hFF, tick: 1'b0};
    if (pos >= 0) begin
      slot = pos / SLOT;
      off  = pos % SLOT;
      if (off >= BLK && digit_en[slot]) begin
        e.seg = m_shadow[slot];
        e.an  = ~(8'd1 << slot);
      end
    end
    e.tick = enable && (pos == FRAME - 1);
    if (!enable) begin
      pos = -1;
    end else if (pos < 0 || pos == FRAME - 1) begin
      pos = 0;
      for (int k = 0; k < 8; k++) m_shadow[k] = seg_data[k*7 +: 7];
    end else begin
      pos++;
    end
    q.push_back(e);
    exp_last = e;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic run_until(input int target, input string name);
    int n = 0;
    while (pos != target && n < 4 * FRAME) begin
      cycle();
      n++;
    end
    total++;
    if (pos == target) passed++;
    else $display("FAIL %s: position %0d never reached", name, target);
  endtask

  task automatic model_reset();
    pos = -1;
    for (int k = 0; k < 8; k++) m_shadow[k] = 7'd0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("segment", 32'(segment), 32'(e.seg));
        check("anode_ctrl", 32'(anode_ctrl), 32'(e.an));
        check("frame_tick", 32'(frame_tick), 32'(e.tick));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    model_reset();
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset segment", 32'(segment), 32'd0);
    check("reset anode", 32'(anode_ctrl), 32'hFF);
    check("reset tick", 32'(frame_tick), 32'd0);
    reset_n = 1'b1;
    repeat (5) cycle();

    // Digit k shows k+1, all digits enabled.
    for (int k = 0; k < 8; k++) seg_data[k*7 +: 7] = 7'(k + 1);
    enable = 1'b1;
    repeat (FRAME + 5) cycle();
    run_until(3 * SLOT + BLK + 1, "reach digit3 drive");
    seg_data[6:0] = 7'h7F;
    repeat (2 * FRAME) cycle();

    digit_en = 8'b0000_0101;
    repeat (2 * FRAME) cycle();

    digit_en = 8'hFF;
    run_until(5 * SLOT + BLK + 1, "reach digit5 drive");
    enable = 1'b0;
    repeat (6) cycle();
    enable = 1'b1;
    repeat (FRAME) cycle();

    digit_en = 8'h00;
    repeat (2 * FRAME) cycle();

    for (int i = 0; i < 1500; i++) begin
      cycle();
      if ($urandom_range(199) == 0) enable = ~enable;
      if ($urandom_range(49) == 0) digit_en = 8'($urandom());
      if ($urandom_range(9) == 0) seg_data = 56'({$urandom(), $urandom()});
    end

    // Asynchronous reset while a digit is lit.
    enable = 1'b1;
    digit_en = 8'hFF;
    begin
      int n = 0;
      cycle();
      while (exp_last.an == 8'hFF && n < 4 * FRAME) begin
        cycle();
        n++;
      end
    end
    @(negedge clk);
    #1;
    check("pre-reset anode lit", 32'(anode_ctrl != 8'hFF), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async reset anode", 32'(anode_ctrl), 32'hFF);
    check("async reset segment", 32'(segment), 32'd0);
    model_reset();
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (10) cycle();
    enable = 1'b1;
    repeat (FRAME + 3) cycle();

    @(negedge clk);
    #1;
    check("scoreboard drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
